store_unit: RTL and testbench

Store path of the data-memory interface: computes the effective address from `rs1 + Imm`, checks alignment, and writes the byte, halfword or word from `rs2` into a 32-bit word-addressed memory that has no byte enables. Sub-word stores therefore run a read-modify-write sequence under a small FSM; word stores write directly. It sits beside the load extraction logic on the memory side of the execute/memory stage and shares its `funct3` encodings.

---
 rtl/store_unit_pkg.sv | 35 +++
 rtl/store_merge.sv | 27 ++
 rtl/store_unit.sv | 162 ++++++++++++++++
 tb/tb_store_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared definitions for the data-memory store path: funct3 codes
// (loads and stores share the encoding space) and FSM state encoding.
package store_unit_pkg;

  // Load funct3 codes, used by the load extraction logic next door.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Store FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_WRITE  = 2'd3
  } store_state_t;

  // True when funct3 is one of the three legal store codes.
  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // True when the effective address is not naturally aligned for the access.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == F3_SH) && off[0]) || ((f3 == F3_SW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: inserts store data into the old memory word.
// SB replaces one byte lane, SH one halfword, SW the whole word.
module store_merge
  import store_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  // Start from the old word and overwrite only the lanes being stored.
  always_comb begin
    merged = old_word;
    case (funct3)
      F3_SB: merged[{offset, 3'b000} +: 8] = data[7:0];
      F3_SH: begin
        if (offset[1]) merged[31:16] = data[15:0];
        else           merged[15:0]  = data[15:0];
      end
      F3_SW:   merged = data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store path: effective address, alignment check, and word write into a
// memory without byte enables (sub-word stores use read-modify-write).
module store_unit
  import store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] Imm,
  input  logic [31:0] rs2,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_wack,
  output logic        done,
  output logic        misaligned,
  output logic        illegal
);

  store_state_t r_state, w_state_nxt;

  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [2:0]  r_f3,   w_f3_nxt;

  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_wdata,    w_wdata_nxt;
  logic        r_re,   w_re_nxt;
  logic        r_we,   w_we_nxt;
  logic        r_done, w_done_nxt;
  logic        r_mis,  w_mis_nxt;
  logic        r_ill,  w_ill_nxt;

  logic        w_idle;
  logic [31:0] w_eff_addr;
  logic [31:0] w_mg_data;
  logic [2:0]  w_mg_f3;
  logic [1:0]  w_mg_off;
  logic [31:0] w_merged;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_eff_addr = rs1 + Imm;

  // The single merge instance serves both paths: in IDLE it sees the live
  // request (SW, old word ignored), later it sees the latched request.
  assign w_mg_data = w_idle ? rs2            : r_data;
  assign w_mg_f3   = w_idle ? funct3         : r_f3;
  assign w_mg_off  = w_idle ? w_eff_addr[1:0] : r_addr[1:0];

  store_merge u_merge (
    .old_word (mem_rdata),
    .data     (w_mg_data),
    .funct3   (w_mg_f3),
    .offset   (w_mg_off),
    .merged   (w_merged)
  );

  // State and registered outputs; reset abandons any in-flight sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_f3       <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_mis      <= 1'b0;
      r_ill      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_f3       <= w_f3_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_re       <= w_re_nxt;
      r_we       <= w_we_nxt;
      r_done     <= w_done_nxt;
      r_mis      <= w_mis_nxt;
      r_ill      <= w_ill_nxt;
    end
  end

  // Next-state logic; outputs are computed one cycle early and registered.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_f3_nxt       = r_f3;
    w_mem_addr_nxt = r_mem_addr;
    w_wdata_nxt    = r_wdata;
    w_re_nxt       = 1'b0;
    w_we_nxt       = 1'b0;
    w_done_nxt     = 1'b0;
    w_mis_nxt      = 1'b0;
    w_ill_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_mem_addr_nxt = '0;
        if (req_valid) begin
          w_addr_nxt = w_eff_addr;
          w_data_nxt = rs2;
          w_f3_nxt   = funct3;
          if (!is_store_f3(funct3)) begin
            w_ill_nxt = 1'b1;
          end else if (is_misaligned(funct3, w_eff_addr[1:0])) begin
            w_mis_nxt = 1'b1;
          end else if (funct3 == F3_SW) begin
            w_state_nxt    = ST_WRITE;
            w_we_nxt       = 1'b1;
            w_mem_addr_nxt = {w_eff_addr[31:2], 2'b00};
            w_wdata_nxt    = w_merged;
          end else begin
            w_state_nxt    = ST_READ;
            w_re_nxt       = 1'b1;
            w_mem_addr_nxt = {w_eff_addr[31:2], 2'b00};
          end
        end
      end
      ST_READ: begin
        w_state_nxt = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (mem_rvalid) begin
          w_state_nxt = ST_WRITE;
          w_we_nxt    = 1'b1;
          w_wdata_nxt = w_merged;
        end
      end
      ST_WRITE: begin
        w_we_nxt = 1'b1;
        if (mem_wack) begin
          w_state_nxt    = ST_IDLE;
          w_we_nxt       = 1'b0;
          w_done_nxt     = 1'b1;
          w_mem_addr_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready  = w_idle & ~rst;
  assign mem_addr   = r_mem_addr;
  assign mem_re     = r_re;
  assign mem_we     = r_we;
  assign mem_wdata  = r_wdata;
  assign done       = r_done;
  assign misaligned = r_mis;
  assign illegal    = r_ill;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: the bench plays the memory, keeps a
// word-level memory model, and predicts each transaction byte by byte.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1, Imm, rs2;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_wack;
  logic        done, misaligned, illegal;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_model [int unsigned];

  store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .rs1        (rs1),
    .Imm        (Imm),
    .rs2        (rs2),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_wack   (mem_wack),
    .done       (done),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-level model of a store into an old word.
  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] b [4];
    int unsigned n;
    logic [31:0] r;
    for (int unsigned i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int unsigned i = 0; i < n; i++) b[(off + i) % 4] = d[8*i +: 8];
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  // One full store transaction; rdly/wdly are extra wait cycles on rvalid/wack.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] b, input logic [31:0] imm,
                           input logic [31:0] d, input int rdly, input int wdly);
    logic [31:0] ea, wa, old, expw;
    bit is_ill, is_mis;
    ea     = b + imm;
    wa     = {ea[31:2], 2'b00};
    is_ill = (f3 > 3'd2);
    is_mis = !is_ill && (((f3 == 3'd1) && (ea % 2 != 0)) || ((f3 == 3'd2) && (ea % 4 != 0)));

    @(negedge clk);
    check("ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; funct3 = f3; rs1 = b; Imm = imm; rs2 = d;
    @(negedge clk);
    req_valid = 1'b0; rs2 = $urandom; rs1 = $urandom; Imm = $urandom;

    if (is_ill || is_mis) begin
      check("illegal_pulse", {31'b0, illegal}, {31'b0, is_ill});
      check("misaligned_pulse", {31'b0, misaligned}, {31'b0, is_mis});
      check("err_no_re", {31'b0, mem_re}, 32'd0);
      check("err_no_we", {31'b0, mem_we}, 32'd0);
      check("err_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      check("err_pulse_end", {30'b0, illegal, misaligned}, 32'd0);
      check("err_no_we2", {30'b0, mem_re, mem_we}, 32'd0);
      return;
    end

    if (f3 == 3'd2) begin
      expw = d;
    end else begin
      check("rmw_re", {31'b0, mem_re}, 32'd1);
      check("rmw_raddr", mem_addr, wa);
      check("rmw_busy", {31'b0, req_ready}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = $urandom;   // stray, state READ
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("re_one_cycle", {31'b0, mem_re}, 32'd0);
      for (int i = 0; i < rdly; i++) begin
        mem_wack = 1'b1;                          // stray, state WAIT_R
        @(negedge clk);
        check("waitr_no_we", {30'b0, mem_re, mem_we}, 32'd0);
        check("waitr_addr", mem_addr, wa);
      end
      mem_wack = 1'b0;
      old = mem_read(wa);
      expw = model_store(old, d, f3, ea[1:0]);
      mem_rvalid = 1'b1; mem_rdata = old;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end

    check("we_asserted", {31'b0, mem_we}, 32'd1);
    check("w_addr", mem_addr, wa);
    check("wdata", mem_wdata, expw);
    check("no_re_in_write", {31'b0, mem_re}, 32'd0);
    for (int i = 0; i < wdly; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;    // stray, state WRITE
      @(negedge clk);
      check("we_held", {31'b0, mem_we}, 32'd1);
      check("wdata_stable", mem_wdata, expw);
      check("waddr_stable", mem_addr, wa);
      check("no_early_done", {31'b0, done}, 32'd0);
    end
    mem_rvalid = 1'b0;
    mem_wack = 1'b1;
    @(negedge clk);
    mem_wack = 1'b0;
    mem_model[wa] = expw;
    check("done_pulse", {31'b0, done}, 32'd1);
    check("we_dropped", {31'b0, mem_we}, 32'd0);
    check("ready_after", {31'b0, req_ready}, 32'd1);
    check("addr_idle", mem_addr, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; funct3 = '0; rs1 = '0; Imm = '0; rs2 = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_outs", {27'b0, mem_re, mem_we, done, misaligned, illegal}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_store(3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 0, 0);
    mem_model[32'h200] = 32'h11223344;
    run_store(3'b000, 32'h200, 32'd3, 32'h000000AA, 0, 0);
    check("sb_result", mem_model[32'h200], 32'hAA223344);
    mem_model[32'h300] = 32'h55667788;
    run_store(3'b001, 32'h300, 32'h2, 32'h1234CAFE, 2, 2);
    check("sh_result", mem_model[32'h300], 32'hCAFE7788);
    run_store(3'b001, 32'h400, 32'h1, 32'h5555, 0, 0);
    run_store(3'b010, 32'h400, 32'h2, 32'h5555, 0, 0);
    run_store(3'b011, 32'h400, 32'h0, 32'h5555, 0, 0);
    mem_model[32'h0] = 32'h01020304;
    run_store(3'b000, 32'hFFFFFFFE, 32'd3, 32'h000000EE, 1, 0);
    check("wrap_result", mem_model[32'h0], 32'h0102EE04);

    // Reset while waiting for read data of an SB.
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h500; Imm = 32'h1; rs2 = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_we", {30'b0, mem_re, mem_we}, 32'd0);
    check("rst_mid_addr", mem_addr, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
    check("rst_mid_no_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check("rst_mid_no_we2", {28'b0, mem_re, mem_we, done, illegal}, 32'd0);

    // Randomized traffic against the memory model.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      run_store(f3, 32'h1000 + 32'($urandom_range(0, 63)), 32'($urandom_range(0, 15)) - 32'd8,
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
